// File: rtl/csr_access_unit.sv
// Zicsr initiator: reads the CSR in EX, merges it with rs1/zimm, and issues a registered
// write-back, the old-value return and illegal-access exceptions from a single WB stage.
module csr_access_unit #(
  parameter int XLEN          = 32,
  parameter int ILLEGAL_CAUSE = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [4:0]      req_rd,
  input  logic [XLEN-1:0] req_pc,
  input  logic [1:0]      current_mode,
  input  logic            stall,
  input  logic            flush,
  output logic [11:0]     csr_address_r,
  input  logic [XLEN-1:0] csr_data,
  output logic            csr_we,
  output logic [11:0]     csr_address_wb,
  output logic [XLEN-1:0] csr_wb,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            exception_pending,
  output logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] pc_exc
);

  localparam logic [XLEN-1:0] CAUSE_CODE = {1'b0, (XLEN-1)'(ILLEGAL_CAUSE)};

  // Handshake: a request transfers on a cycle where req_valid && req_ready && !flush;
  // req_ready depends only on stall, never on req_valid.
  logic            accept;
  logic            fwd;
  logic            write_flag;
  logic            illegal;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;

  logic            wb_valid;
  logic            wb_write;
  logic            wb_illegal;
  logic [11:0]     wb_addr;
  logic [XLEN-1:0] wb_wdata;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_old;
  logic [XLEN-1:0] wb_pc;
  logic            strobe_ok;

  assign req_ready     = !stall;
  assign accept        = req_valid && req_ready && !flush;
  assign csr_address_r = req_addr;

  // The register file commits one edge after csr_we, so a back-to-back read of the
  // same CSR must take the value still sitting in WB.
  assign fwd     = wb_valid && wb_write && (wb_addr == req_addr);
  assign old_val = fwd ? wb_wdata : csr_data;

  always_comb begin
    operand    = req_op[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_data;
    new_val    = operand;
    case (req_op[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      default: new_val = old_val & ~operand;
    endcase
    write_flag = (req_op[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
    illegal    = (req_addr[9:8] > current_mode) ||
                 (write_flag && (req_addr[11:10] == 2'b11));
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wb_valid   <= 1'b0;
      wb_write   <= 1'b0;
      wb_illegal <= 1'b0;
      wb_addr    <= '0;
      wb_wdata   <= '0;
      wb_rd      <= '0;
      wb_old     <= '0;
      wb_pc      <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (!stall) begin
      wb_valid <= accept;
      if (accept) begin
        // wb_write only records writes that will really be issued, which also keeps
        // illegal requests out of the forwarding path.
        wb_write   <= write_flag && !illegal;
        wb_illegal <= illegal;
        wb_addr    <= req_addr;
        wb_wdata   <= new_val;
        wb_rd      <= req_rd;
        wb_old     <= old_val;
        wb_pc      <= req_pc;
      end
    end
  end

  assign strobe_ok         = wb_valid && !stall && !flush;
  assign csr_we            = strobe_ok && wb_write;
  assign rd_we             = strobe_ok && !wb_illegal && (wb_rd != 5'd0);
  assign exception_pending = wb_valid && wb_illegal && !flush;
  assign csr_address_wb    = wb_addr;
  assign csr_wb            = wb_wdata;
  assign rd_addr           = wb_rd;
  assign rd_data           = wb_old;
  assign cause             = wb_illegal ? CAUSE_CODE : '0;
  assign pc_exc            = wb_pc;

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR register-file interface.
- Accepts decoded Zicsr instructions from execute: CSRRW/S/C and CSRRWI/SI/CI.
- Drives the read address, merges the read value with rs1/zimm, and issues a registered write-back to the CSR register file.
- Returns the old CSR value to the integer register file. Raises illegal-instruction exceptions for privilege and read-only violations.

Parameters:
XLEN, 32, data width.
ILLEGAL_CAUSE, 2, mcause code driven for illegal CSR access (interrupt bit 0).

Ports:
clk  in  1  clock.
nrst  in  1  reset, synchronous, active-low.
req_valid  in  1  CSR instruction present in EX.
req_ready  out  1  unit can accept the request this cycle.
req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
req_addr  in  12  CSR address.
req_rs1_idx  in  5  rs1 index; also the zimm value for the I forms.
req_rs1_data  in  XLEN  rs1 operand.
req_rd  in  5  destination register.
req_pc  in  XLEN  instruction PC.
current_mode  in  2  privilege: U=00, S=01, M=11.
stall  in  1  pipeline stall.
flush  in  1  kill all in-flight work.
csr_address_r  out  12  CSR read address.
csr_data  in  XLEN  CSR read data (combinational).
csr_we  out  1  CSR write strobe.
csr_address_wb  out  12  CSR write address.
csr_wb  out  XLEN  CSR write data.
rd_we  out  1  integer register write enable.
rd_addr  out  5  integer destination register.
rd_data  out  XLEN  old CSR value.
exception_pending  out  1  illegal CSR access.
cause  out  XLEN  exception cause.
pc_exc  out  XLEN  faulting PC.

Behaviour:

Structure:
- Two stages: EX is combinational; WB is a register bank holding valid, addr, wdata, write flag, rd, old value, illegal flag, and pc.
- csr_address_r = req_addr, combinational.
- All outputs are driven from the WB registers.

Reset (nrst=0 at a clock edge):
- WB valid=0.
- csr_we=0, rd_we=0, exception_pending=0.
- csr_address_wb=0, csr_wb=0, rd_addr=0, rd_data=0, cause=0, pc_exc=0.

Handshake:
- req_ready = !stall.
- A request is accepted when req_valid && req_ready && !flush.
- Latency: accepted request → WB outputs valid the next cycle. Throughput is 1 per cycle.

Old value and forwarding:
- old = csr_data, except when WB valid && WB write && WB addr==req_addr: old = csr_wb (bypasses the register file's one-cycle write delay).

Operand and write data:
- operand = req_rs1_data for op[2]=0; {27'b0, req_rs1_idx} for op[2]=1.
- new value: RW = operand; RS = old | operand; RC = old & ~operand.

Write flag:
- RW/RWI: always write.
- RS/RC/RSI/RCI: write only if req_rs1_idx != 0.

Illegal access (either condition):
- req_addr[9:8] > current_mode.
- Write flag set and req_addr[11:10]==2'b11.

On illegal:
- WB illegal=1, csr_we=0, rd_we=0.
- exception_pending=1, cause={1'b0, ILLEGAL_CAUSE zero-extended}, pc_exc=req_pc.

Legal WB valid:
- csr_we = write flag.
- rd_we = (rd != 0).
- rd_data = old. Old value is always returned, including for RW.
- exception_pending=0.

Stall and flush:
- Stall: WB registers hold; outputs stay asserted but csr_we and rd_we are gated to 0 while stall=1. The write commits on the first non-stalled cycle.
- Flush: WB valid cleared at the edge; all strobes gated to 0 in the flush cycle. Flush beats stall.
- No request accepted and no stall/flush: WB valid=0; csr_we, rd_we, exception_pending all 0.
- csr_we and exception_pending are never both 1.
- Reset mid-operation discards WB contents; no write is issued.

Test Plan:
- M-mode, CSRRW 0x340 with rs1_data=0xDEADBEEF, rd=5, csr_data=0x11 → next cycle csr_we=1, csr_address_wb=0x340, csr_wb=0xDEADBEEF, rd_we=1, rd_data=0x11.
- CSRRS 0x300, rs1_idx=0, csr_data=0x88 → csr_we=0, rd_we=1, rd_data=0x88. Same with CSRRSI zimm=3 → csr_wb=0x8B.
- Back-to-back: CSRRW 0x340←0xA, then CSRRC 0x340 with rs1_data=0x2 while csr_data still reads stale 0 → second csr_wb=0x8, rd_data=0xA (forwarded).
- U-mode CSRRS 0x300 rs1_idx=1, req_pc=0x80 → exception_pending=1, cause=2, pc_exc=0x80, csr_we=0, rd_we=0. Also CSRRW 0xF14 in M-mode → exception, cause=2.
- Write held 2 cycles by stall → csr_we=0 during stall, then exactly one csr_we pulse. Flush asserted with stall → no csr_we ever.
- nrst=0 one cycle while WB holds a pending write → all outputs 0 next cycle, no csr_we.
